// File: rtl/square_animator_pkg.sv
// Constants shared with the VGA controller and the animator's state type.
package square_animator_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int RGB_W    = 8;
    localparam int CNT_W    = 11;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } anim_state_e;
endpackage

// File: rtl/square_axis_mover.sv
// One axis of the square's position: a position/direction register that bounces
// between 0 and LIMIT-SQ_SIZE in STEP increments whenever step_i is high.
module square_axis_mover
    import square_animator_pkg::*;
#(
    parameter int LIMIT   = 640,
    parameter int SQ_SIZE = 32,
    parameter int STEP    = 2,
    parameter int POS0    = 100,
    parameter bit DIR0    = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             step_i,
    output logic [CNT_W-1:0] pos_o
);
    localparam int            MAX_INT  = LIMIT - SQ_SIZE;
    localparam logic [CNT_W:0] MAX_EXT  = MAX_INT[CNT_W:0];
    localparam logic [CNT_W:0] STEP_EXT = STEP[CNT_W:0];

    logic [CNT_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;   // 0 = increasing, 1 = decreasing

    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (step_i) begin
            if (!dir_q) begin
                if (({1'b0, pos_q} + STEP_EXT) >= MAX_EXT) begin
                    pos_d = MAX_EXT[CNT_W-1:0];
                    dir_d = 1'b1;
                end else begin
                    pos_d = pos_q + STEP_EXT[CNT_W-1:0];
                end
            end else begin
                if ({1'b0, pos_q} <= STEP_EXT) begin
                    pos_d = '0;
                    dir_d = 1'b0;
                end else begin
                    pos_d = pos_q - STEP_EXT[CNT_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pos_q <= POS0[CNT_W-1:0];
            dir_q <= DIR0;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos_o = pos_q;
endmodule

// File: rtl/square_animator.sv
// Pixel source for a single bouncing square: registered RGB per pixel enable,
// position stepped once per frame on the first blanking line while MOVE_N is low.
module square_animator
    import square_animator_pkg::*;
#(
    parameter int          SQ_SIZE = 32,
    parameter int          STEP    = 2,
    parameter int          X0      = 100,
    parameter int          Y0      = 100,
    parameter bit          X_DIR0  = 1'b0,
    parameter bit          Y_DIR0  = 1'b0,
    parameter logic [23:0] BG_RGB  = 24'h000040
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             PIX_EN,
    input  logic [CNT_W-1:0] HCNT,
    input  logic [CNT_W-1:0] VCNT,
    input  logic             IAA,
    input  logic             MOVE_N,
    input  logic [2:0]       COLOR_SEL,
    output logic [RGB_W-1:0] PIX_R,
    output logic [RGB_W-1:0] PIX_G,
    output logic [RGB_W-1:0] PIX_B,
    output logic             FRAME_TICK
);
    localparam logic [CNT_W-1:0] V_TICK  = V_ACTIVE[CNT_W-1:0];
    localparam logic [CNT_W:0]   SQ_EXT  = SQ_SIZE[CNT_W:0];

    logic [1:0]       move_sync_q;
    anim_state_e      state_q, state_d;
    logic             tick_now, axis_step, frame_tick_q;
    logic [CNT_W-1:0] x_pos, y_pos;
    logic [CNT_W:0]   x_end, y_end;
    logic             in_sq;
    logic [23:0]      sq_rgb, rgb_q, rgb_d;

    assign tick_now  = PIX_EN && (VCNT == V_TICK) && (HCNT == '0);
    assign axis_step = tick_now && (state_d == ST_RUN);

    // The state decision and the position step share one edge, so motion starts
    // on the very tick that first sees MOVE_N low.
    always_comb begin
        state_d = state_q;
        if (tick_now) begin
            state_d = move_sync_q[1] ? ST_STOP : ST_RUN;
        end
    end

    square_axis_mover #(
        .LIMIT(H_ACTIVE), .SQ_SIZE(SQ_SIZE), .STEP(STEP), .POS0(X0), .DIR0(X_DIR0)
    ) u_x (
        .clk_i(CLOCK_50), .rst_n_i(RESET_N), .step_i(axis_step), .pos_o(x_pos)
    );

    square_axis_mover #(
        .LIMIT(V_ACTIVE), .SQ_SIZE(SQ_SIZE), .STEP(STEP), .POS0(Y0), .DIR0(Y_DIR0)
    ) u_y (
        .clk_i(CLOCK_50), .rst_n_i(RESET_N), .step_i(axis_step), .pos_o(y_pos)
    );

    // End coordinates carry an extra bit so a square at the right edge cannot wrap.
    assign x_end = {1'b0, x_pos} + SQ_EXT;
    assign y_end = {1'b0, y_pos} + SQ_EXT;
    assign in_sq = (HCNT >= x_pos) && ({1'b0, HCNT} < x_end) &&
                   (VCNT >= y_pos) && ({1'b0, VCNT} < y_end);
    assign sq_rgb = (COLOR_SEL == 3'b000) ? 24'hFFFFFF :
                    {{RGB_W{COLOR_SEL[2]}}, {RGB_W{COLOR_SEL[1]}}, {RGB_W{COLOR_SEL[0]}}};

    always_comb begin
        rgb_d = rgb_q;
        if (PIX_EN) begin
            if (!IAA)       rgb_d = '0;
            else if (in_sq) rgb_d = sq_rgb;
            else            rgb_d = BG_RGB;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            move_sync_q  <= 2'b11;
            state_q      <= ST_STOP;
            frame_tick_q <= 1'b0;
            rgb_q        <= '0;
        end else begin
            move_sync_q  <= {move_sync_q[0], MOVE_N};
            state_q      <= state_d;
            frame_tick_q <= tick_now;
            rgb_q        <= rgb_d;
        end
    end

    assign PIX_R      = rgb_q[23:16];
    assign PIX_G      = rgb_q[15:8];
    assign PIX_B      = rgb_q[7:0];
    assign FRAME_TICK = frame_tick_q;
endmodule

// File: tb/tb_square_animator.sv
// Bench for square_animator: three parameterisations share one stimulus stream and
// are checked every pixel enable against a plain-arithmetic model of the square.
module tb_square_animator;
    import square_animator_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic [10:0] hcnt = '0, vcnt = '0;
    logic        iaa = 1'b0;
    logic        move_n = 1'b1;
    logic [2:0]  csel = 3'b000;

    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic        ft_a, ft_b, ft_c;

    int tests = 0;
    int fails = 0;

    int mx[3], my[3], mdx[3], mdy[3];
    int x0s[3]  = '{100, 606, 1};
    int y0s[3]  = '{100, 100, 1};
    int dx0s[3] = '{1, 1, -1};
    int dy0s[3] = '{1, 1, -1};

    always #5 clk = ~clk;

    square_animator dut_a (
        .CLOCK_50(clk), .RESET_N(rst_n), .PIX_EN(pix_en), .HCNT(hcnt), .VCNT(vcnt),
        .IAA(iaa), .MOVE_N(move_n), .COLOR_SEL(csel),
        .PIX_R(r_a), .PIX_G(g_a), .PIX_B(b_a), .FRAME_TICK(ft_a)
    );
    square_animator #(.X0(606), .Y0(100)) dut_b (
        .CLOCK_50(clk), .RESET_N(rst_n), .PIX_EN(pix_en), .HCNT(hcnt), .VCNT(vcnt),
        .IAA(iaa), .MOVE_N(move_n), .COLOR_SEL(csel),
        .PIX_R(r_b), .PIX_G(g_b), .PIX_B(b_b), .FRAME_TICK(ft_b)
    );
    square_animator #(.X0(1), .Y0(1), .X_DIR0(1'b1), .Y_DIR0(1'b1)) dut_c (
        .CLOCK_50(clk), .RESET_N(rst_n), .PIX_EN(pix_en), .HCNT(hcnt), .VCNT(vcnt),
        .IAA(iaa), .MOVE_N(move_n), .COLOR_SEL(csel),
        .PIX_R(r_c), .PIX_G(g_c), .PIX_B(b_c), .FRAME_TICK(ft_c)
    );

    logic [23:0] rgb_out[3];
    logic [2:0]  ft_out;
    int          xs_out[3], ys_out[3];
    assign rgb_out[0] = {r_a, g_a, b_a};
    assign rgb_out[1] = {r_b, g_b, b_b};
    assign rgb_out[2] = {r_c, g_c, b_c};
    assign ft_out     = {ft_c, ft_b, ft_a};
    always_comb begin
        xs_out[0] = int'(dut_a.x_pos); ys_out[0] = int'(dut_a.y_pos);
        xs_out[1] = int'(dut_b.x_pos); ys_out[1] = int'(dut_b.y_pos);
        xs_out[2] = int'(dut_c.x_pos); ys_out[2] = int'(dut_c.y_pos);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %h", name, act);
        end
    endtask

    function automatic logic [23:0] model_rgb(int k, int h, int v, bit ia, bit [2:0] cs);
        if (!ia) return 24'h0;
        if (h >= mx[k] && h < mx[k] + 32 && v >= my[k] && v < my[k] + 32) begin
            if (cs == 3'b000) return 24'hFFFFFF;
            return {cs[2] ? 8'hFF : 8'h00, cs[1] ? 8'hFF : 8'h00, cs[0] ? 8'hFF : 8'h00};
        end
        return 24'h000040;
    endfunction

    function automatic void bounce(input int p, input int d, input int lim,
                                   output int np, output int nd);
        np = p; nd = d;
        if (d > 0) begin
            if (p + 2 >= lim - 32) begin np = lim - 32; nd = -1; end
            else np = p + 2;
        end else begin
            if (p <= 2) begin np = 0; nd = 1; end
            else np = p - 2;
        end
    endfunction

    // Model update and per-cycle comparison.
    bit          c_pe, c_ia, c_tk;
    int          c_h, c_v;
    bit [2:0]    c_cs;
    logic [23:0] c_exp[3];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mx[k] = x0s[k]; my[k] = y0s[k]; mdx[k] = dx0s[k]; mdy[k] = dy0s[k];
            end
        end else begin
            c_pe = pix_en; c_h = int'(hcnt); c_v = int'(vcnt); c_ia = iaa; c_cs = csel;
            c_tk = c_pe && c_v == 480 && c_h == 0;
            if (c_pe)
                for (int k = 0; k < 3; k++) c_exp[k] = model_rgb(k, c_h, c_v, c_ia, c_cs);
            if (c_tk && !move_n) begin
                for (int k = 0; k < 3; k++) begin
                    bounce(mx[k], mdx[k], 640, mx[k], mdx[k]);
                    bounce(my[k], mdy[k], 480, my[k], mdy[k]);
                end
            end
            #1;
            if (ft_out !== {3{c_tk}}) begin
                tests++; fails++;
                $display("[TB] FAIL frame_tick: got %b, expected %b", ft_out, {3{c_tk}});
            end else if (c_tk) begin
                check("frame_tick", 32'(ft_out), 32'(3'b111));
            end
            if (c_pe) begin
                for (int k = 0; k < 3; k++)
                    check($sformatf("rgb[%0d] @(%0d,%0d,iaa=%0d)", k, c_h, c_v, c_ia),
                          32'(rgb_out[k]), 32'(c_exp[k]));
            end
            if (c_tk) begin
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("x[%0d]", k), 32'(xs_out[k]), 32'(mx[k]));
                    check($sformatf("y[%0d]", k), 32'(ys_out[k]), 32'(my[k]));
                end
            end
        end
    end

    task automatic pixel(input int h, input int v, input bit ia);
        @(negedge clk);
        hcnt = 11'(h); vcnt = 11'(v); iaa = ia; pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick();
        pixel(0, 480, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(2);
        check("reset rgb_a", 32'(rgb_out[0]), 32'h0);
        check("reset ft", 32'(ft_out), 32'h0);
        #2 rst_n = 1'b1;
        idle(4);

        pixel(100, 100, 1'b1);
        check("lit white (100,100)", 32'(rgb_out[0]), 32'hFFFFFF);
        pixel(99, 100, 1'b1);
        check("lit bg (99,100)", 32'(rgb_out[0]), 32'h000040);
        pixel(100, 100, 1'b0);
        check("lit iaa0", 32'(rgb_out[0]), 32'h0);
        pixel(131, 131, 1'b1);
        pixel(132, 100, 1'b1);
        pixel(100, 132, 1'b1);
        pixel(607, 100, 1'b1);
        pixel(639, 131, 1'b1);

        csel = 3'b100;
        pixel(100, 100, 1'b1);
        check("lit red only", 32'(rgb_out[0]), 32'hFF0000);
        csel = 3'b011;
        pixel(110, 110, 1'b1);
        csel = 3'b000;
        pixel(110, 110, 1'b1);
        check("lit white csel0", 32'(rgb_out[0]), 32'hFFFFFF);

        tick();
        check("lit frozen x", 32'(xs_out[0]), 32'd100);

        move_n = 1'b0;
        idle(4);
        pixel(1, 480, 1'b0);
        pixel(0, 479, 1'b1);
        tick();
        check("lit b x tick1", 32'(xs_out[1]), 32'd608);
        check("lit c x tick1", 32'(xs_out[2]), 32'd0);
        check("lit c y tick1", 32'(ys_out[2]), 32'd0);
        tick();
        check("lit b x tick2", 32'(xs_out[1]), 32'd606);
        check("lit c x tick2", 32'(xs_out[2]), 32'd2);
        check("lit c y tick2", 32'(ys_out[2]), 32'd2);
        tick();
        check("lit a x tick3", 32'(xs_out[0]), 32'd106);
        check("lit a y tick3", 32'(ys_out[0]), 32'd106);
        check("model a x tick3", 32'(mx[0]), 32'd106);
        pixel(106, 106, 1'b1);
        pixel(105, 106, 1'b1);
        pixel(137, 137, 1'b1);
        pixel(138, 137, 1'b1);

        for (int i = 0; i < 22; i++) begin
            tick();
            pixel(i * 29, 200 + i, 1'b1);
        end
        check("lit a x=150", 32'(xs_out[0]), 32'd150);

        @(negedge clk);
        hcnt = 11'd160; vcnt = 11'd180; iaa = 1'b1; pix_en = 1'b1;
        @(posedge clk);
        #3;
        pix_en = 1'b0;
        check("pre-reset white", 32'(rgb_out[0]), 32'hFFFFFF);
        rst_n = 1'b0;
        #1;
        check("async rst rgb_a", 32'(rgb_out[0]), 32'h0);
        check("async rst rgb_b", 32'(rgb_out[1]), 32'h0);
        idle(3);
        #2 rst_n = 1'b1;
        idle(1);
        check("post-reset x", 32'(xs_out[0]), 32'd100);
        check("post-reset state", 32'(dut_a.state_q), 32'(ST_STOP));
        move_n = 1'b1;
        idle(4);
        tick();
        check("frozen after reset", 32'(xs_out[0]), 32'd100);
        pixel(100, 100, 1'b1);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
